pwm_update_sequencer: RTL and testbench

Controller that sequences duty/phase updates into the PWM datapath. It arbitrates between two update sources, normal mode and STM (spatio-temporal modulation), and selects the winning source on the duty/phase mux. It waits for a SYS_TIME-aligned boundary so all transducers take the new values on the same phase. It then issues the single-cycle DIN_VALID to the PWM preconditioner, and watches DOUT_VALID for completion with a timeout.

---
 rtl/pwm_ctl_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 43 ++++
 rtl/pwm_update_sequencer.sv | 154 +++++++++++++++
 tb/tb_pwm_update_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctl_pkg.sv
// pwm_ctl_pkg
// Shared types and constants for the PWM update sequencer.
//   seq_state_t          : sequencer FSM states
//   SRC_NORMAL / SRC_STM : source ids, also used as bit indices into request/grant vectors
//   DEF_*                : default parameter values
//   timer_width()        : bits needed to hold a timer value up to timeout-1
package pwm_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_ISSUE     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_t;

  localparam logic SRC_NORMAL = 1'b0;
  localparam logic SRC_STM    = 1'b1;

  localparam int DEF_SYNC_BITS = 9;
  localparam int DEF_TIMEOUT   = 64;
  localparam int DEF_CNT_WIDTH = 16;

  function automatic int timer_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-input round-robin arbiter. Produces a combinational one-hot grant and
// remembers which source won last so the other one wins the next tie.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req[1:0]     : requests, indexed by SRC_NORMAL / SRC_STM
//   i_commit       : high when the current grant is actually taken
//   o_grant[1:0]   : one-hot grant (all zero when nothing requests)
module rr_arbiter2
  import pwm_ctl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_commit,
  output logic [1:0] o_grant
);

  logic       r_last_grant;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    case (i_req)
      2'b01:   w_grant[SRC_NORMAL] = 1'b1;
      2'b10:   w_grant[SRC_STM]    = 1'b1;
      // Tie: whoever did not win last time goes first.
      2'b11:   w_grant = (r_last_grant == SRC_STM) ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  // Resetting to STM means the very first tie goes to the normal source.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= SRC_STM;
    end else if (i_commit && (|i_req)) begin
      r_last_grant <= w_grant[SRC_STM] ? SRC_STM : SRC_NORMAL;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/pwm_update_sequencer.sv
// pwm_update_sequencer
// Sequences duty/phase updates into the PWM datapath: arbitrates between the
// normal and STM sources, waits for a SYS_TIME boundary so every transducer
// switches on the same phase, fires DIN_VALID, then waits for DOUT_VALID with
// a timeout.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   SYS_TIME              : free-running system time
//   REQ_NORMAL, REQ_STM   : level requests, held until granted
//   GRANT_NORMAL/STM      : one-cycle grant pulses
//   SEL_STM               : duty/phase mux select (1 = STM), held from grant to completion
//   DIN_VALID, DOUT_VALID : preconditioner start pulse / completion pulse
//   BUSY                  : high whenever the sequencer is not idle
//   TIMEOUT_ERR, CLR_ERR  : sticky timeout flag and its clear
//   UPDATE_CNT            : wrapping count of successful updates
module pwm_update_sequencer
  import pwm_ctl_pkg::*;
#(
  parameter int SYNC_BITS = DEF_SYNC_BITS,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [63:0]          SYS_TIME,
  input  logic                 REQ_NORMAL,
  input  logic                 REQ_STM,
  output logic                 GRANT_NORMAL,
  output logic                 GRANT_STM,
  output logic                 SEL_STM,
  output logic                 DIN_VALID,
  input  logic                 DOUT_VALID,
  output logic                 BUSY,
  output logic                 TIMEOUT_ERR,
  input  logic                 CLR_ERR,
  output logic [CNT_WIDTH-1:0] UPDATE_CNT
);

  localparam int             TW       = timer_width(TIMEOUT);
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT - 1);

  seq_state_t           r_state, w_state_next;
  logic                 r_grant_normal, w_grant_normal_next;
  logic                 r_grant_stm, w_grant_stm_next;
  logic                 r_sel_stm, w_sel_stm_next;
  logic                 r_din_valid, w_din_valid_next;
  logic                 r_busy, w_busy_next;
  logic                 r_timeout_err, w_timeout_err_next;
  logic [CNT_WIDTH-1:0] r_update_cnt, w_update_cnt_next;
  logic [TW-1:0]        r_timer, w_timer_next;

  logic [1:0]           w_req;
  logic [1:0]           w_grant;
  logic                 w_sync;
  logic                 w_unused_time;

  assign w_req[SRC_NORMAL] = REQ_NORMAL;
  assign w_req[SRC_STM]    = REQ_STM;

  // Only the low bits define the update boundary.
  assign w_sync        = (SYS_TIME[SYNC_BITS-1:0] == '0);
  assign w_unused_time = ^SYS_TIME[63:SYNC_BITS];

  // The arbiter only commits its decision while idle, so requests that move
  // after a grant never disturb last_grant mid-sequence.
  rr_arbiter2 u_arb (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_req    (w_req),
    .i_commit (r_state == ST_IDLE),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_state_next        = r_state;
    w_grant_normal_next = 1'b0;
    w_grant_stm_next    = 1'b0;
    w_din_valid_next    = 1'b0;
    w_sel_stm_next      = r_sel_stm;
    w_timer_next        = r_timer;
    w_update_cnt_next   = r_update_cnt;
    // A timeout below overrides this, so a set coinciding with a clear wins.
    w_timeout_err_next  = r_timeout_err & ~CLR_ERR;

    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_grant_normal_next = w_grant[SRC_NORMAL];
          w_grant_stm_next    = w_grant[SRC_STM];
          w_sel_stm_next      = w_grant[SRC_STM];
          w_state_next        = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        // DIN_VALID is registered, so it lands in the ISSUE cycle.
        if (w_sync) begin
          w_din_valid_next = 1'b1;
          w_state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_timer_next = '0;
        w_state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Completion is checked first so it beats a same-cycle timeout.
        if (DOUT_VALID) begin
          w_update_cnt_next = r_update_cnt + CNT_WIDTH'(1);
          w_state_next      = ST_IDLE;
        end else if (r_timer == TMR_LAST) begin
          w_timeout_err_next = 1'b1;
          w_state_next       = ST_IDLE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= ST_IDLE;
      r_grant_normal <= 1'b0;
      r_grant_stm    <= 1'b0;
      r_sel_stm      <= 1'b0;
      r_din_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_update_cnt   <= '0;
      r_timer        <= '0;
    end else begin
      r_state        <= w_state_next;
      r_grant_normal <= w_grant_normal_next;
      r_grant_stm    <= w_grant_stm_next;
      r_sel_stm      <= w_sel_stm_next;
      r_din_valid    <= w_din_valid_next;
      r_busy         <= w_busy_next;
      r_timeout_err  <= w_timeout_err_next;
      r_update_cnt   <= w_update_cnt_next;
      r_timer        <= w_timer_next;
    end
  end

  assign GRANT_NORMAL = r_grant_normal;
  assign GRANT_STM    = r_grant_stm;
  assign SEL_STM      = r_sel_stm;
  assign DIN_VALID    = r_din_valid;
  assign BUSY         = r_busy;
  assign TIMEOUT_ERR  = r_timeout_err;
  assign UPDATE_CNT   = r_update_cnt;

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// tb_pwm_update_sequencer
// Directed bench for pwm_update_sequencer with SYNC_BITS=4, TIMEOUT=8,
// CNT_WIDTH=4. Inputs change 1 time unit after each rising edge and outputs
// are sampled at the same point, i.e. they show the state after that edge.
module tb_pwm_update_sequencer;

  localparam int SB = 4;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          CLK;
  logic          RST_N;
  logic [63:0]   sys_time;
  logic          REQ_NORMAL, REQ_STM;
  logic          GRANT_NORMAL, GRANT_STM, SEL_STM, DIN_VALID, BUSY;
  logic          DOUT_VALID, TIMEOUT_ERR, CLR_ERR;
  logic [CW-1:0] UPDATE_CNT;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  pwm_update_sequencer #(
    .SYNC_BITS (SB),
    .TIMEOUT   (TO),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .SYS_TIME     (sys_time),
    .REQ_NORMAL   (REQ_NORMAL),
    .REQ_STM      (REQ_STM),
    .GRANT_NORMAL (GRANT_NORMAL),
    .GRANT_STM    (GRANT_STM),
    .SEL_STM      (SEL_STM),
    .DIN_VALID    (DIN_VALID),
    .DOUT_VALID   (DOUT_VALID),
    .BUSY         (BUSY),
    .TIMEOUT_ERR  (TIMEOUT_ERR),
    .CLR_ERR      (CLR_ERR),
    .UPDATE_CNT   (UPDATE_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // One clock; system time advances once per cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
    sys_time = sys_time + 64'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant_n"}, GRANT_NORMAL, 0);
    chk({tag, "_grant_s"}, GRANT_STM, 0);
    chk({tag, "_din"},     DIN_VALID, 0);
    chk({tag, "_busy"},    BUSY, 0);
    chk({tag, "_sel"},     SEL_STM, 0);
    chk({tag, "_err"},     TIMEOUT_ERR, 0);
    chk({tag, "_cnt"},     UPDATE_CNT, 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    RST_N = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic wait_din(input logic exp_stm);
    int n = 0;
    while (!DIN_VALID && n < 40) begin
      chk("sel_stable_sync", SEL_STM, exp_stm);
      tick();
      n++;
    end
    chk("din_seen", DIN_VALID, 1);
  endtask

  // Grant through DIN_VALID; returns with DIN_VALID high.
  task automatic front(input logic exp_stm, input bit drop);
    int n = 0;
    while (!(GRANT_NORMAL || GRANT_STM) && n < 8) begin
      tick();
      n++;
    end
    chk("grant_seen",    GRANT_NORMAL | GRANT_STM, 1);
    chk("grant_stm",     GRANT_STM, exp_stm);
    chk("grant_normal",  GRANT_NORMAL, !exp_stm);
    chk("sel_at_grant",  SEL_STM, exp_stm);
    chk("busy_at_grant", BUSY, 1);
    if (drop) begin
      REQ_NORMAL = 1'b0;
      REQ_STM    = 1'b0;
    end
    tick();
    chk("grant_one_cycle", GRANT_NORMAL | GRANT_STM, 0);
    wait_din(exp_stm);
  endtask

  // DOUT_VALID is sampled while the timer holds d.
  task automatic back(input logic exp_stm, input int d);
    tick();
    chk("din_one_cycle", DIN_VALID, 0);
    chk("busy_wait_done", BUSY, 1);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("sel_stable_done", SEL_STM, exp_stm);
    end
    DOUT_VALID = 1'b1;
    tick();
    DOUT_VALID = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("cnt_after_done",  UPDATE_CNT, exp_cnt);
    chk("busy_after_done", BUSY, 0);
    $display("update src=%s dout_delay=%0d cnt=%0d", exp_stm ? "STM" : "NORMAL", d, UPDATE_CNT);
  endtask

  initial begin
    int n;
    RST_N      = 1'b0;
    REQ_NORMAL = 1'b1;
    REQ_STM    = 1'b0;
    DOUT_VALID = 1'b0;
    CLR_ERR    = 1'b0;
    sys_time   = 64'd0;

    // Single normal request present at reset release, time starting at 5.
    tick();
    tick();
    chk_reset("por");
    RST_N    = 1'b1;
    sys_time = 64'd5;
    tick();
    chk("t1_grant_n", GRANT_NORMAL, 1);
    chk("t1_grant_s", GRANT_STM, 0);
    chk("t1_busy",    BUSY, 1);
    chk("t1_sel",     SEL_STM, 0);
    chk("t1_din",     DIN_VALID, 0);
    REQ_NORMAL = 1'b0;
    tick();
    chk("t1_grant_low", GRANT_NORMAL, 0);
    // Time 16 is sampled at the 11th edge after the grant edge.
    n = 0;
    while (!DIN_VALID && n < 30) begin
      tick();
      n++;
    end
    chk("t1_din_latency", n, 10);
    back(1'b0, 1);
    chk("t1_cnt", UPDATE_CNT, 1);

    // Tie: N, S, N, S with SEL_STM tracking each grant.
    do_reset();
    REQ_NORMAL = 1'b1;
    REQ_STM    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic e;
      e = ((i % 2) == 1);
      front(e, i == 3);
      back(e, i + 1);
    end
    chk("tie_cnt", UPDATE_CNT, 4);

    // Timeout with no completion, then clear.
    REQ_NORMAL = 1'b1;
    front(1'b0, 1'b1);
    tick();
    chk("to_din_low", DIN_VALID, 0);
    repeat (TO - 1) tick();
    chk("to_err_early", TIMEOUT_ERR, 0);
    chk("to_busy_early", BUSY, 1);
    tick();
    chk("to_err_set", TIMEOUT_ERR, 1);
    chk("to_busy_idle", BUSY, 0);
    chk("to_cnt", UPDATE_CNT, exp_cnt);
    $display("update src=NORMAL timeout err=%0d cnt=%0d", TIMEOUT_ERR, UPDATE_CNT);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("to_err_clr", TIMEOUT_ERR, 0);

    // Completion on the last timer value: success, no error.
    REQ_NORMAL = 1'b1;
    front(1'b0, 1'b1);
    back(1'b0, TO - 1);
    chk("coll_err", TIMEOUT_ERR, 0);

    // Clear held across a fresh timeout: set wins.
    REQ_NORMAL = 1'b1;
    front(1'b0, 1'b1);
    CLR_ERR = 1'b1;
    repeat (TO) tick();
    chk("clrset_err_before", TIMEOUT_ERR, 0);
    tick();
    chk("clrset_err_set", TIMEOUT_ERR, 1);
    CLR_ERR = 1'b0;
    tick();
    chk("clrset_sticky", TIMEOUT_ERR, 1);
    $display("update src=NORMAL timeout_with_clear err=%0d cnt=%0d", TIMEOUT_ERR, UPDATE_CNT);

    // Stray DOUT_VALID in IDLE and in WAIT_SYNC.
    DOUT_VALID = 1'b1;
    tick();
    DOUT_VALID = 1'b0;
    chk("stray_idle_cnt", UPDATE_CNT, exp_cnt);
    chk("stray_idle_busy", BUSY, 0);
    sys_time   = 64'd100;
    REQ_NORMAL = 1'b1;
    tick();
    chk("stray_grant", GRANT_NORMAL, 1);
    REQ_NORMAL = 1'b0;
    DOUT_VALID = 1'b1;
    tick();
    DOUT_VALID = 1'b0;
    chk("stray_sync_cnt", UPDATE_CNT, exp_cnt);
    chk("stray_sync_busy", BUSY, 1);
    chk("stray_sync_din", DIN_VALID, 0);
    wait_din(1'b0);
    back(1'b0, 3);

    // Reset while waiting for completion.
    REQ_NORMAL = 1'b1;
    front(1'b0, 1'b1);
    tick();
    chk("mid_busy", BUSY, 1);
    RST_N = 1'b0;
    #1;
    chk_reset("midrst");
    tick();
    RST_N   = 1'b1;
    REQ_STM = 1'b1;
    exp_cnt = 0;
    front(1'b1, 1'b1);
    back(1'b1, 2);

    // Counter wrap: 17 updates on a 4-bit counter.
    do_reset();
    REQ_NORMAL = 1'b1;
    for (int i = 0; i < 17; i++) begin
      front(1'b0, i == 16);
      back(1'b0, 0);
    end
    chk("wrap_cnt", UPDATE_CNT, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
